// File: rtl/hamming74_decoder.sv
// Hamming(7,4) decoder: syndrome, single-bit correction, nibble extract, display counters.
// Latency: 2 cycles accept-to-out_valid, 1 word/cycle when out_ready stays high.
// Backpressure: stalls via valid/ready; in_ready drops only when both stages are full and output is stalled.
module hamming74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:1]       in_codeword,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] corr_count
);

    logic             v1, v2;
    logic [7:1]       cw1;
    logic [2:0]       syn1;
    logic [2:0]       syn_in;
    logic [7:1]       fixed;
    logic             adv1, adv2, out_hs;
    logic [CNT_W-1:0] cnt_max;

    assign cnt_max  = {CNT_W{1'b1}};
    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;
    assign out_valid = v2;
    assign out_hs   = v2 && out_ready;

    always_comb begin
        syn_in[0] = in_codeword[1] ^ in_codeword[3] ^ in_codeword[5] ^ in_codeword[7];
        syn_in[1] = in_codeword[2] ^ in_codeword[3] ^ in_codeword[6] ^ in_codeword[7];
        syn_in[2] = in_codeword[4] ^ in_codeword[5] ^ in_codeword[6] ^ in_codeword[7];
    end

    // The syndrome names the flipped position directly; zero matches no bit.
    always_comb begin
        fixed = cw1;
        for (int i = 1; i <= 7; i++) begin
            if (syn1 == 3'(i)) begin
                fixed[i] = ~cw1[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            cw1           <= '0;
            syn1          <= '0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    cw1  <= in_codeword;
                    syn1 <= syn_in;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    out_data      <= {fixed[7], fixed[6], fixed[5], fixed[3]};
                    out_syndrome  <= syn1;
                    out_corrected <= (syn1 != 3'd0);
                end
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_counts) begin
            word_count <= '0;
            corr_count <= '0;
        end else if (out_hs) begin
            if (word_count != cnt_max) begin
                word_count <= word_count + CNT_W'(1);
            end
            if (out_corrected && (corr_count != cnt_max)) begin
                corr_count <= corr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming74_decoder.sv
// Directed bench for hamming74_decoder: reset, clean/corrupted words, streaming with stalls, counters.
module tb_hamming74_decoder;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:1]       in_codeword = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       out_data;
    logic [2:0]       out_syndrome;
    logic             out_corrected;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             clear_counts = 1'b0;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] corr_count;

    int checks = 0;
    int passes = 0;

    hamming74_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_codeword(in_codeword), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
        .out_valid(out_valid), .out_ready(out_ready),
        .clear_counts(clear_counts), .word_count(word_count), .corr_count(corr_count)
    );

    always #5 clk = ~clk;

    // Reference encoder: data at 3/5/6/7, even parity at 1/2/4.
    function automatic logic [7:1] enc(input logic [3:0] d);
        logic [7:1] c;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        return c;
    endfunction

    function automatic logic [7:1] flip(input logic [7:1] c, input int pos);
        logic [7:1] r;
        r = c;
        if (pos >= 1 && pos <= 7) r[pos] = ~r[pos];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_codeword = 7'b1010101; out_ready = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
        checks++; if ({out_data, out_syndrome, out_corrected} !== 8'h00)
            $display("FAIL reset_fields: got %h want 00", {out_data, out_syndrome, out_corrected}); else passes++;
        checks++; if ({word_count, corr_count} !== '0)
            $display("FAIL reset_counts: got %h/%h want 0/0", word_count, corr_count); else passes++;
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
        step(); step();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_no_accept: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_clean();
        out_ready = 1'b1; in_codeword = 7'b1010101; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL clean_early: got %b want 0", out_valid); else passes++;
        step();
        checks++; if ({out_valid, out_data, out_syndrome, out_corrected} !== {1'b1, 4'b1011, 3'd0, 1'b0})
            $display("FAIL clean_out: got v%b d%b s%0d c%b want v1 d1011 s0 c0",
                     out_valid, out_data, out_syndrome, out_corrected); else passes++;
        step();
        checks++; if ({word_count, corr_count} !== {4'd1, 4'd0})
            $display("FAIL clean_counts: got %0d/%0d want 1/0", word_count, corr_count); else passes++;
    endtask

    task automatic test_single_errors();
        logic [8:0] exp_out;
        out_ready = 1'b1;
        for (int idx = 0; idx <= 128; idx++) begin
            if (idx < 128) begin
                in_valid = 1'b1;
                in_codeword = flip(enc(4'(idx / 8)), idx % 8);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (idx >= 1) begin
                exp_out = {1'b1, 4'((idx - 1) / 8), 3'((idx - 1) % 8), ((idx - 1) % 8) != 0};
                checks++;
                if ({out_valid, out_data, out_syndrome, out_corrected} !== exp_out)
                    $display("FAIL single_err[%0d]: got v%b d%b s%0d c%b want %b",
                             idx - 1, out_valid, out_data, out_syndrome, out_corrected, exp_out);
                else passes++;
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:1] words [8];
        logic [3:0] expd [8];
        logic [2:0] exps [8];
        logic [8:0] held;
        int  sent, recv;
        bit  stalled, saw_full;
        sent = 0; recv = 0; stalled = 0; saw_full = 0; held = '0;
        for (int k = 0; k < 8; k++) begin
            expd[k]  = 4'((k * 3 + 1) % 16);
            exps[k]  = 3'(k % 8);
            words[k] = flip(enc(expd[k]), k % 8);
        end
        clear_cnt();
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready   = !(cyc >= 4 && cyc <= 6);
            in_valid    = (sent < 8);
            in_codeword = words[sent & 7];
            #1;
            checks++;
            if (in_ready !== (out_ready || (sent - recv < 2)))
                $display("FAIL b2b_in_ready[%0d]: got %b want %b", cyc, in_ready, out_ready || (sent - recv < 2));
            else passes++;
            if (stalled) begin
                checks++;
                if ({out_valid, out_data, out_syndrome, out_corrected} !== held)
                    $display("FAIL b2b_hold[%0d]: got %h want %h", cyc,
                             {out_valid, out_data, out_syndrome, out_corrected}, held);
                else passes++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (recv >= 8 || {out_data, out_syndrome} !== {expd[recv & 7], exps[recv & 7]})
                    $display("FAIL b2b_word[%0d]: got d%b s%0d want d%b s%0d", recv,
                             out_data, out_syndrome, expd[recv & 7], exps[recv & 7]);
                else passes++;
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, out_data, out_syndrome, out_corrected};
            if (!in_ready) saw_full = 1;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (recv != 8 || sent != 8) $display("FAIL b2b_total: got sent %0d recv %0d want 8/8", sent, recv); else passes++;
        checks++; if (!saw_full) $display("FAIL b2b_backpressure: in_ready never fell, want a fall"); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_extra: got out_valid %b want 0", out_valid); else passes++;
        checks++; if ({word_count, corr_count} !== {4'd8, 4'd7})
            $display("FAIL b2b_counts: got %0d/%0d want 8/7", word_count, corr_count); else passes++;
    endtask

    task automatic test_saturation();
        clear_cnt();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_codeword = flip(enc(4'(i % 16)), (i % 7) + 1);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if ({word_count, corr_count} !== {4'd15, 4'd15})
            $display("FAIL sat_counts: got %0d/%0d want 15/15", word_count, corr_count); else passes++;
        in_valid = 1'b1; in_codeword = flip(enc(4'h6), 2);
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if ({word_count, corr_count} !== {4'd15, 4'd15})
            $display("FAIL sat_hold: got %0d/%0d want 15/15", word_count, corr_count); else passes++;
    endtask

    task automatic test_clear_handshake();
        out_ready = 1'b1; in_valid = 1'b1; in_codeword = flip(enc(4'h9), 4);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) $display("FAIL clr_pre_valid: got %b want 1", out_valid); else passes++;
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        checks++; if ({word_count, corr_count} !== '0)
            $display("FAIL clr_counts: got %0d/%0d want 0/0", word_count, corr_count); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL clr_consumed: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1; in_valid = 1'b1; in_codeword = flip(enc(4'h3), 7);
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if ({word_count, corr_count} !== {4'd1, 4'd1})
            $display("FAIL mid_pre_counts: got %0d/%0d want 1/1", word_count, corr_count); else passes++;
        out_ready = 1'b0;
        in_valid = 1'b1; in_codeword = enc(4'hA);
        step();
        in_codeword = flip(enc(4'h5), 1);
        step();
        in_valid = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b01)
            $display("FAIL mid_full: got in_ready %b out_valid %b want 0/1", in_ready, out_valid); else passes++;
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        checks++; if ({out_valid, out_data, out_syndrome, out_corrected} !== 9'h000)
            $display("FAIL mid_rst_out: got %h want 000", {out_valid, out_data, out_syndrome, out_corrected}); else passes++;
        checks++; if ({word_count, corr_count} !== '0)
            $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", word_count, corr_count); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", in_ready); else passes++;
        in_valid = 1'b1; in_codeword = flip(enc(4'hC), 6);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_after_1: got %b want 0", out_valid); else passes++;
        step();
        checks++; if ({out_valid, out_data, out_syndrome, out_corrected} !== {1'b1, 4'hC, 3'd6, 1'b1})
            $display("FAIL mid_after_2: got v%b d%h s%0d c%b want v1 dC s6 c1",
                     out_valid, out_data, out_syndrome, out_corrected); else passes++;
        step();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_errors();
        test_back_to_back();
        test_saturation();
        test_clear_handshake();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
Receiving end of the Hamming(7,4) link. It accepts 7-bit codewords (bits [7:1], even parity, parity at positions 1/2/4, data at 3/5/6/7), computes the syndrome, corrects any single-bit error and returns the 4-bit data nibble. It is a stallable 2-stage valid/ready pipeline that sits downstream of the encoder and fault injector. It also keeps saturating counters of words delivered and words corrected, for display.

Parameters:
CNT_W, 16, width of word_count and corr_count (legal range 4..32)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_codeword  input  7  received codeword, indexed [7:1]
in_valid  input  1  in_codeword is valid this cycle
in_ready  output  1  decoder can accept a word this cycle
out_data  output  4  corrected nibble {c7,c6,c5,c3}
out_syndrome  output  3  {s2,s1,s0}; equals the flipped bit position, 0 when clean
out_corrected  output  1  1 when out_syndrome != 0
out_valid  output  1  out_* fields are valid
out_ready  input  1  downstream accepts this cycle
clear_counts  input  1  synchronous clear of both counters
word_count  output  CNT_W  number of output handshakes, saturating
corr_count  output  CNT_W  number of output handshakes with out_corrected=1, saturating

Behaviour:
- Syndrome:
  - s0 = c1^c3^c5^c7
  - s1 = c2^c3^c6^c7
  - s2 = c4^c5^c6^c7
- Correction: if the syndrome S is nonzero, flip bit S of the codeword, then extract data as d0=c3, d1=c5, d2=c6, d3=c7.
- Every single-bit error is corrected, including errors in the parity bits (positions 1, 2, 4); data is unchanged in those cases but out_corrected is still 1.
- Double-bit errors are not detected. They produce a wrong nonzero syndrome and miscorrection. This is intentional.
- Pipeline:
  - Stage 1 registers the codeword and the syndrome.
  - Stage 2 registers the corrected data, the syndrome and the corrected flag.
  - Valid bits are v1 and v2.
- Advance rules:
  - adv2 = !v2 | out_ready
  - adv1 = !v1 | adv2
  - in_ready = adv1 (combinational)
- Accept occurs when in_valid & in_ready. Latency is exactly 2 cycles from accept to out_valid when there are no stalls. Throughput is 1 word/cycle when out_ready stays high.
- Stall: while out_valid & !out_ready, all out_* fields hold stable. Stage 1 keeps its word if full. No word is dropped or duplicated.
- Stage registers load only on their advance condition. Data registers are don't-care while their valid bit is 0, but must still reset to 0.
- Counters:
  - Both update on an output handshake (out_valid & out_ready).
  - word_count += 1; corr_count += 1 if out_corrected.
  - Each counter saturates at 2^CNT_W-1 and holds there.
- clear_counts sets both counters to 0 in the following cycle. clear_counts takes priority over a simultaneous increment. It does not affect the pipeline.
- Reset (rst_n=0 at a clock edge):
  - v1=v2=0, out_valid=0
  - out_data=0, out_syndrome=0, out_corrected=0
  - word_count=0, corr_count=0
  - in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight words. No output handshake occurs in the reset cycle.
- in_ready may be high while rst_n=0; any word presented during reset is not accepted.

Test Plan:
- Clean word: in_codeword=7'b1010101 (data 4'b1011), out_ready=1 -> 2 cycles later out_data=4'b1011, out_syndrome=0, out_corrected=0, word_count=1, corr_count=0.
- Single error, every position: inject each of the 7 flips of 7'b1010101 (e.g. bit 5 → 7'b1000101, bit 3 → 7'b1010001) -> out_data=4'b1011 in all cases, out_syndrome equals the flipped position (5 and 3 respectively), out_corrected=1. Exhaustively check all 16 nibbles × 8 error cases (none + 7) against a reference model.
- Back-to-back plus backpressure:
  - Stream 8 words with in_valid held high.
  - Drop out_ready for 3 cycles mid-stream.
  - Required: in_ready falls once both stages are full, outputs stay stable while stalled, all 8 words come out in order with none lost or duplicated, and word_count=8.
- Saturation: CNT_W=4, send 20 corrupted words -> word_count=15, corr_count=15, both holding.
- clear_counts asserted in the same cycle as an output handshake -> both counters read 0 the next cycle.
- Reset mid-stream: rst_n=0 for 1 cycle with both stages full -> out_valid=0, all outputs 0, counters 0. The next accepted word appears after exactly 2 cycles.
